// File: rtl/punc_mem_arbiter_if.sv
// Bus bundle between the three PUnC memory requesters, the shared
// single-port memory and punc_mem_arbiter. Requester index:
// 0 = fetch, 1 = data, 2 = debug. The master side is the requester and
// memory environment; the slave side is the arbiter.
interface punc_mem_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [15:0] addr2;
    logic [15:0] wdata0;
    logic [15:0] wdata1;
    logic [15:0] wdata2;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [15:0] rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        busy;
    logic [1:0]  owner;

    modport slave (
        input  req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
        output gnt, done, rdata, mem_addr, mem_wdata, mem_we, busy, owner
    );

    modport master (
        output req, we, addr0, addr1, addr2, wdata0, wdata1, wdata2, mem_rdata,
        input  gnt, done, rdata, mem_addr, mem_wdata, mem_we, busy, owner
    );
endinterface

// File: rtl/punc_mem_arbiter.sv
// punc_mem_arbiter: serialises fetch / data / debug accesses onto the
// single-port PUnC memory. One transaction at a time: latch in IDLE,
// drive the memory in ISSUE, wait out MEM_LAT read cycles in WAIT,
// pulse done in DONE.
//
// Optional feature: define PUNC_ARB_RR_EN for round-robin arbitration
// (search starts after the last winner). Without it the priority is
// fixed at data > fetch > debug and no pointer register is built.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transaction; winner and its fields latched when req != 0
// ISSUE  | memory address/data/we driven, gnt[owner] high
// WAIT   | read in progress, counting down the memory latency
// DONE   | done[owner] high for one cycle, rdata valid
module punc_mem_arbiter #(
    parameter int MEM_LAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    punc_mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] LP_LAT = 2'(MEM_LAT);

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_owner;
    logic        r_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic [15:0] r_rdata;
    logic [1:0]  r_cnt;

    logic        w_req_any;
    logic [1:0]  w_win_idx;
    logic        w_sel_we;
    logic [15:0] w_sel_addr;
    logic [15:0] w_sel_wdata;
    logic        w_capture;

    logic [2:0]  w_owner_oh;
    logic [2:0]  w_gnt;
    logic [2:0]  w_done;
    logic        w_mem_we;
    logic        w_busy;

    assign w_req_any = |bus.req;

`ifdef PUNC_ARB_RR_EN
    logic [1:0] r_ptr;

    // Round-robin pointer remembers the owner of the last issued transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (r_state == S_ISSUE) begin
            r_ptr <= r_owner;
        end
    end

    // Winner search starts one past the last winner and wraps 2 -> 0.
    always_comb begin
        w_win_idx = 2'd0;
        case (r_ptr)
            2'd1: begin
                if (bus.req[2])      w_win_idx = 2'd2;
                else if (bus.req[0]) w_win_idx = 2'd0;
                else                 w_win_idx = 2'd1;
            end
            2'd2: begin
                if (bus.req[0])      w_win_idx = 2'd0;
                else if (bus.req[1]) w_win_idx = 2'd1;
                else                 w_win_idx = 2'd2;
            end
            default: begin
                if (bus.req[1])      w_win_idx = 2'd1;
                else if (bus.req[2]) w_win_idx = 2'd2;
                else                 w_win_idx = 2'd0;
            end
        endcase
    end
`else
    // Fixed priority: data (1) > fetch (0) > debug (2).
    always_comb begin
        w_win_idx = 2'd0;
        if (bus.req[1])      w_win_idx = 2'd1;
        else if (bus.req[0]) w_win_idx = 2'd0;
        else                 w_win_idx = 2'd2;
    end
`endif

    // Select the winning requester's write flag, address and write data.
    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = 16'h0000;
        w_sel_wdata = 16'h0000;
        case (w_win_idx)
            2'd0: begin
                w_sel_we    = bus.we[0];
                w_sel_addr  = bus.addr0;
                w_sel_wdata = bus.wdata0;
            end
            2'd1: begin
                w_sel_we    = bus.we[1];
                w_sel_addr  = bus.addr1;
                w_sel_wdata = bus.wdata1;
            end
            default: begin
                w_sel_we    = bus.we[2];
                w_sel_addr  = bus.addr2;
                w_sel_wdata = bus.wdata2;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; writes and zero-latency reads skip WAIT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (r_we || (LP_LAT == 2'd0)) w_next = S_DONE;
                else                          w_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt <= 2'd1) w_next = S_DONE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Read data is sampled on the last cycle the memory needs to produce it.
    assign w_capture = ((r_state == S_ISSUE) && !r_we && (LP_LAT == 2'd0)) ||
                       ((r_state == S_WAIT) && (r_cnt <= 2'd1));

    // Transaction fields, latency counter and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner     <= 2'd0;
            r_we        <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
            r_rdata     <= 16'h0000;
            r_cnt       <= 2'd0;
        end else begin
            if ((r_state == S_IDLE) && w_req_any) begin
                r_owner     <= w_win_idx;
                r_we        <= w_sel_we;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
            end
            if ((r_state == S_ISSUE) && !r_we) begin
                r_cnt <= LP_LAT;
            end else if ((r_state == S_WAIT) && (r_cnt != 2'd0)) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_capture) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

    // Outputs decoded from the registered state so they are glitch-free.
    always_comb begin
        w_owner_oh = 3'b000;
        case (r_owner)
            2'd0:    w_owner_oh = 3'b001;
            2'd1:    w_owner_oh = 3'b010;
            default: w_owner_oh = 3'b100;
        endcase
        w_gnt    = 3'b000;
        w_done   = 3'b000;
        w_mem_we = 1'b0;
        w_busy   = (r_state != S_IDLE);
        case (r_state)
            S_ISSUE: begin
                w_gnt    = w_owner_oh;
                w_mem_we = r_we;
            end
            S_DONE: begin
                w_done = w_owner_oh;
            end
            default: begin
                w_gnt = 3'b000;
            end
        endcase
    end

    assign bus.gnt       = w_gnt;
    assign bus.done      = w_done;
    assign bus.mem_we    = w_mem_we;
    assign bus.busy      = w_busy;
    assign bus.owner     = r_owner;
    assign bus.rdata     = r_rdata;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Directed bench for punc_mem_arbiter: three instances with MEM_LAT = 0, 2
// and 3, each with its own memory model delaying the address by MEM_LAT.
module tb_punc_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    punc_mem_arbiter_if if0 ();
    punc_mem_arbiter_if if2 ();
    punc_mem_arbiter_if if3 ();

    punc_mem_arbiter #(.MEM_LAT(0)) u_lat0 (.clk(clk), .rst(rst), .bus(if0.slave));
    punc_mem_arbiter #(.MEM_LAT(2)) u_lat2 (.clk(clk), .rst(rst), .bus(if2.slave));
    punc_mem_arbiter #(.MEM_LAT(3)) u_lat3 (.clk(clk), .rst(rst), .bus(if3.slave));

    logic [15:0] mem [0:65535];
    logic [15:0] p2a, p2b, p3a, p3b, p3c;

    always @(posedge clk) begin
        p2a <= if2.mem_addr;
        p2b <= p2a;
        p3a <= if3.mem_addr;
        p3b <= p3a;
        p3c <= p3b;
    end

    assign if0.mem_rdata = mem[if0.mem_addr];
    assign if2.mem_rdata = mem[p2b];
    assign if3.mem_rdata = mem[p3c];

    // gnt/done exclusivity and one-hotness on the zero-latency instance.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (((if0.gnt != 3'b000) && (if0.done != 3'b000)) ||
                ($countones(if0.gnt) > 1) || ($countones(if0.done) > 1)) begin
                errors++;
                $display("FAIL onehot_excl: gnt=%b done=%b", if0.gnt, if0.done);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        if0.req = 3'b000; if0.we = 3'b000;
        if0.addr0 = 16'h0; if0.addr1 = 16'h0; if0.addr2 = 16'h0;
        if0.wdata0 = 16'h0; if0.wdata1 = 16'h0; if0.wdata2 = 16'h0;
        if2.req = 3'b000; if2.we = 3'b000;
        if2.addr0 = 16'h0; if2.addr1 = 16'h0; if2.addr2 = 16'h0;
        if2.wdata0 = 16'h0; if2.wdata1 = 16'h0; if2.wdata2 = 16'h0;
        if3.req = 3'b000; if3.we = 3'b000;
        if3.addr0 = 16'h0; if3.addr1 = 16'h0; if3.addr2 = 16'h0;
        if3.wdata0 = 16'h0; if3.wdata1 = 16'h0; if3.wdata2 = 16'h0;
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        pulse_reset();
        checks++;
        if ({if0.busy, if0.gnt, if0.done, if0.mem_we, if0.owner} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/gnt/done/we/owner=%b expected 0",
                     {if0.busy, if0.gnt, if0.done, if0.mem_we, if0.owner});
        end
        checks++;
        if ({if0.rdata, if0.mem_addr, if0.mem_wdata} !== 48'h0) begin
            errors++;
            $display("FAIL reset_regs: rdata=%h addr=%h wdata=%h expected 0",
                     if0.rdata, if0.mem_addr, if0.mem_wdata);
        end
    endtask

    task automatic test_fetch_read;
        if0.req = 3'b001; if0.we = 3'b000; if0.addr0 = 16'h3000;
        tick();
        checks++;
        if ({if0.gnt, if0.mem_addr, if0.mem_we} !== {3'b001, 16'h3000, 1'b0}) begin
            errors++;
            $display("FAIL fetch_issue: gnt=%b addr=%h we=%b expected 001 3000 0",
                     if0.gnt, if0.mem_addr, if0.mem_we);
        end
        tick();
        checks++;
        if ({if0.done, if0.rdata, if0.gnt} !== {3'b001, 16'h1234, 3'b000}) begin
            errors++;
            $display("FAIL fetch_done: done=%b rdata=%h gnt=%b expected 001 1234 000",
                     if0.done, if0.rdata, if0.gnt);
        end
        if0.req = 3'b000;
        tick();
        checks++;
        if (if0.busy !== 1'b0) begin
            errors++;
            $display("FAIL fetch_idle: busy=%b expected 0", if0.busy);
        end
    endtask

    task automatic test_data_write;
        if0.req = 3'b010; if0.we = 3'b010;
        if0.addr1 = 16'h4000; if0.wdata1 = 16'hBEEF;
        tick();
        checks++;
        if ({if0.mem_we, if0.mem_addr, if0.mem_wdata, if0.gnt} !==
            {1'b1, 16'h4000, 16'hBEEF, 3'b010}) begin
            errors++;
            $display("FAIL write_issue: we=%b addr=%h wdata=%h gnt=%b expected 1 4000 beef 010",
                     if0.mem_we, if0.mem_addr, if0.mem_wdata, if0.gnt);
        end
        tick();
        checks++;
        if ({if0.mem_we, if0.done, if0.rdata} !== {1'b0, 3'b010, 16'h1234}) begin
            errors++;
            $display("FAIL write_done: we=%b done=%b rdata=%h expected 0 010 1234",
                     if0.mem_we, if0.done, if0.rdata);
        end
        if0.req = 3'b000; if0.we = 3'b000;
        tick();
        checks++;
        if ({if0.busy, if0.mem_we, if0.mem_addr, if0.mem_wdata} !==
            {1'b0, 1'b0, 16'h4000, 16'hBEEF}) begin
            errors++;
            $display("FAIL write_hold: busy=%b we=%b addr=%h wdata=%h expected 0 0 4000 beef",
                     if0.busy, if0.mem_we, if0.mem_addr, if0.mem_wdata);
        end
    endtask

    task automatic test_contention;
        int exp_seq [6];
`ifdef PUNC_ARB_RR_EN
        exp_seq = '{1, 2, 0, 1, 2, 0};
`else
        exp_seq = '{1, 1, 1, 1, 1, 1};
`endif
        pulse_reset();
        if0.req = 3'b111; if0.we = 3'b000;
        if0.addr0 = 16'h0100; if0.addr1 = 16'h0101; if0.addr2 = 16'h0102;
        for (int i = 0; i < 6; i++) begin
            logic [2:0] eo;
            logic [15:0] ed;
            eo = 3'(1 << exp_seq[i]);
            ed = 16'h1100 + 16'(exp_seq[i]);
            tick();
            checks++;
            if (if0.gnt !== eo) begin
                errors++;
                $display("FAIL contend_gnt[%0d]: gnt=%b expected %b", i, if0.gnt, eo);
            end
            tick();
            checks++;
            if ({if0.done, if0.rdata} !== {eo, ed}) begin
                errors++;
                $display("FAIL contend_done[%0d]: done=%b rdata=%h expected %b %h",
                         i, if0.done, if0.rdata, eo, ed);
            end
            tick();
        end
        if0.req = 3'b000;
        tick();
    endtask

    task automatic test_lat2_read;
        if2.req = 3'b100; if2.we = 3'b000; if2.addr2 = 16'h0010;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (if2.busy !== 1'b1) begin
                errors++;
                $display("FAIL lat2_busy[%0d]: busy=%b expected 1", c, if2.busy);
            end
            if (c < 4) begin
                checks++;
                if (if2.done !== 3'b000) begin
                    errors++;
                    $display("FAIL lat2_early_done[%0d]: done=%b expected 000", c, if2.done);
                end
            end
        end
        checks++;
        if ({if2.done, if2.rdata} !== {3'b100, 16'hA5A5}) begin
            errors++;
            $display("FAIL lat2_done: done=%b rdata=%h expected 100 a5a5", if2.done, if2.rdata);
        end
        if2.req = 3'b000;
        tick();
        checks++;
        if (if2.busy !== 1'b0) begin
            errors++;
            $display("FAIL lat2_idle: busy=%b expected 0", if2.busy);
        end
    endtask

    task automatic test_reset_mid_wait;
        bit seen_done;
        bit found;
        int n;
        if3.req = 3'b001; if3.we = 3'b000; if3.addr0 = 16'h2000;
        tick();
        checks++;
        if (if3.gnt !== 3'b001) begin
            errors++;
            $display("FAIL rstw_gnt: gnt=%b expected 001", if3.gnt);
        end
        tick();
        rst = 1'b1;
        if3.req = 3'b000;
        tick();
        checks++;
        if ({if3.busy, if3.gnt, if3.done, if3.mem_we, if3.rdata} !== 24'h0) begin
            errors++;
            $display("FAIL rstw_clear: busy=%b gnt=%b done=%b we=%b rdata=%h expected all 0",
                     if3.busy, if3.gnt, if3.done, if3.mem_we, if3.rdata);
        end
        rst = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (if3.done !== 3'b000) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL rstw_no_done: stray done seen=%b expected 0", seen_done);
        end
        if3.req = 3'b001;
        found = 1'b0;
        n = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (!found && (if3.done !== 3'b000)) begin
                found = 1'b1;
                n = c;
                checks++;
                if ({if3.done, if3.rdata} !== {3'b001, 16'h7777}) begin
                    errors++;
                    $display("FAIL rstw_new_done: done=%b rdata=%h expected 001 7777",
                             if3.done, if3.rdata);
                end
                if3.req = 3'b000;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstw_timeout: done never seen within 10 cycles, expected cycle 5");
        end else if (n != 5) begin
            errors++;
            $display("FAIL rstw_latency: done at cycle %0d expected 5", n);
        end
        if3.req = 3'b000;
    endtask

    task automatic test_req_drop;
        if0.req = 3'b001; if0.we = 3'b000; if0.addr0 = 16'h3000;
        tick();
        checks++;
        if (if0.gnt !== 3'b001) begin
            errors++;
            $display("FAIL drop_gnt: gnt=%b expected 001", if0.gnt);
        end
        if0.req = 3'b000;
        tick();
        checks++;
        if ({if0.done, if0.rdata} !== {3'b001, 16'h1234}) begin
            errors++;
            $display("FAIL drop_done: done=%b rdata=%h expected 001 1234", if0.done, if0.rdata);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({if0.busy, if0.mem_we, if0.gnt, if0.done} !== 8'h00) begin
                errors++;
                $display("FAIL drop_idle[%0d]: busy=%b we=%b gnt=%b done=%b expected all 0",
                         c, if0.busy, if0.mem_we, if0.gnt, if0.done);
            end
        end
    endtask

    initial begin
        clear_inputs();
        mem[16'h3000] = 16'h1234;
        mem[16'h0100] = 16'h1100;
        mem[16'h0101] = 16'h1101;
        mem[16'h0102] = 16'h1102;
        mem[16'h0010] = 16'hA5A5;
        mem[16'h2000] = 16'h7777;
        mem[16'h4000] = 16'h0000;
        mem[16'h0000] = 16'h0000;

        test_reset();
        test_fetch_read();
        test_data_write();
        test_contention();
        test_lat2_read();
        test_reset_mid_wait();
        test_req_drop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/punc_mem_arbiter.md
# punc_mem_arbiter

Shares the single-port 16-bit PUnC memory between three requesters: instruction fetch, data load/store and the debug/loader port. It serialises their transactions through a small FSM, drives the memory address, write data and write enable, and returns read data with a one-cycle completion pulse. It sits between PUnC control/datapath and the memory array, so the memory needs only one address port.

## Interface
Parameters:
- MEM_LAT, default 0: memory read latency in cycles, range 0..3; 0 means a combinational read.

Ports (requester index: 0 = fetch, 1 = data, 2 = debug):
- clk  in  1  clock; every register is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  3  per-requester request; held high until that requester's done.
- we  in  3  per-requester write flag; 1 = write, 0 = read.
- addr0 / addr1 / addr2  in  16 each  request address.
- wdata0 / wdata1 / wdata2  in  16 each  write data.
- gnt  out  3  one-hot; pulses in the ISSUE cycle of the owner.
- done  out  3  one-hot; pulses for one cycle when the owner's transaction completes.
- rdata  out  16  read data; valid while done is high, held until the next capture.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  16  memory read data.
- busy  out  1  high in any state other than IDLE.
- owner  out  2  index of the current or last owner.

## Operation
FSM states: IDLE, ISSUE, WAIT, DONE.

Latching and issue:
- IDLE, with any req bit high: pick the winner, latch owner, we, addr and wdata from that requester, then go to ISSUE.
- ISSUE: drive mem_addr and mem_wdata from the latched fields. Assert mem_we = latched we and gnt[owner] = 1.
  - Write: go to DONE.
  - Read with MEM_LAT = 0: capture mem_rdata into rdata, go to DONE.
  - Read with MEM_LAT > 0: load a counter with MEM_LAT, go to WAIT.

Waiting and completion:
- WAIT: keep mem_addr driven and mem_we = 0, and decrement the counter. When the counter reaches 1, capture mem_rdata into rdata and go to DONE.
- DONE: done[owner] = 1, then go to IDLE. rdata is unchanged on writes.

Default arbitration is fixed priority: data (1) > fetch (0) > debug (2).

Request-side rules:
- Requester fields are sampled only in IDLE. Later changes, including req dropping, do not affect the transaction in flight, and done still pulses.
- A requester that keeps req high through its done cycle is eligible again in the IDLE cycle that follows.

Output rules:
- Outside ISSUE and WAIT: mem_addr and mem_wdata hold their last values; mem_we is 0.
- gnt and done are never asserted in the same cycle.
- At most one bit of gnt and at most one bit of done is ever high.

Reset, taking effect at the next rising edge (including mid-transaction):
- State goes to IDLE and the in-flight transaction is abandoned with no done pulse.
- Outputs: mem_we = 0, gnt = 0, done = 0, busy = 0, owner = 0.
- Registers cleared: rdata = 0, mem_addr = 0, mem_wdata = 0, counter = 0, round-robin pointer = 0.

## Timing
Cycle 0 is the IDLE cycle in which req is sampled.
- Write: ISSUE and mem_we in cycle 1; done in cycle 2; back in IDLE at cycle 3. Throughput is 1 transaction per 3 cycles.
- Read: ISSUE in cycle 1; rdata captured at the end of cycle 1 + MEM_LAT; done in cycle 2 + MEM_LAT. Throughput is 1 transaction per 3 + MEM_LAT cycles.
- Read latency from request to done is 2 + MEM_LAT cycles; write latency is 2 cycles.
- The latency seen by the losing requesters is added on top of the transactions that win ahead of them.
- mem_we and gnt are decoded from registered state, so they are glitch-free relative to clk.

## Configuration
- PUNC_ARB_RR_EN defined: round-robin arbitration.
  - A 2-bit pointer records the last winner and is updated in ISSUE.
  - The search starts at (pointer + 1) mod 3 and wraps 2 → 0.
  - After reset the pointer is 0, so the first search order is 1, 2, 0.
- PUNC_ARB_RR_EN undefined: fixed priority 1 > 0 > 2, and no pointer register exists.

## Test plan
- Reset, then fetch reads 0x3000 with MEM_LAT = 0 and mem[0x3000] = 0x1234 → gnt = 001 in cycle 1 with mem_addr = 0x3000, mem_we = 0; done = 001 in cycle 2 with rdata = 0x1234.
- Data writes 0xBEEF to 0x4000 → mem_we = 1 for exactly one cycle with mem_addr = 0x4000 and mem_wdata = 0xBEEF; done = 010 one cycle later; rdata unchanged.
- req = 111 held continuously, fixed priority → data is served every 3 cycles and fetch and debug never receive gnt.
  - Same stimulus with PUNC_ARB_RR_EN → grant order 1, 2, 0, 1, 2, 0.
- MEM_LAT = 2, debug reads 0x0010, with the memory model returning 0xA5A5 two cycles after the address → busy is high for 4 cycles; done = 100 in cycle 4 with rdata = 0xA5A5.
- rst asserted in WAIT during a MEM_LAT = 3 read → next cycle shows busy = 0 and gnt = done = 0; no done pulse ever follows; a new fetch request is served normally.
- Fetch drops req one cycle after its gnt → done = 001 still pulses at the scheduled cycle; the arbiter returns to IDLE and stays idle with mem_we = 0.
